// File: rtl/spram_arbiter_pkg.sv
// Shared types and helpers for the spram_arbiter slice.
// Optional build macro: SPRAM_ARBITER_FIXED_PRIO_EN (fixed-priority arbitration).
package spram_arbiter_pkg;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_e;

    // Width of a port index; never below one bit so vectors stay legal.
    function automatic int ptr_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    // LSB of port 'port' within a flattened per-port bus of 'width'-bit fields.
    function automatic int field_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Client request/response bus plus single-port RAM port of the spram_arbiter.
// Optional build macro: SPRAM_ARBITER_FIXED_PRIO_EN (does not change this bus).
interface spram_arbiter_if #(
    parameter int address_width = 8,
    parameter int data_width    = 8,
    parameter int num_ports     = 2
);
    logic [num_ports-1:0]               req_valid;
    logic [num_ports-1:0]               req_wren;
    logic [num_ports*address_width-1:0] req_address;
    logic [num_ports*data_width-1:0]    req_data;
    logic [num_ports-1:0]               req_ready;
    logic [num_ports-1:0]               rsp_valid;
    logic [data_width-1:0]              rsp_data;
    logic [address_width-1:0]           ram_address;
    logic [data_width-1:0]              ram_data;
    logic                               ram_wren;
    logic [data_width-1:0]              ram_q;

    modport slave (
        input  req_valid, req_wren, req_address, req_data, ram_q,
        output req_ready, rsp_valid, rsp_data, ram_address, ram_data, ram_wren
    );

    modport master (
        output req_valid, req_wren, req_address, req_data, ram_q,
        input  req_ready, rsp_valid, rsp_data, ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/spram_arbiter_rr.sv
// Combinational grant encoder: rotate-priority from rr_ptr, or plain lowest-index
// priority when SPRAM_ARBITER_FIXED_PRIO_EN is defined.
module spram_arbiter_rr
    import spram_arbiter_pkg::*;
#(
    parameter int num_ports = 2,
    parameter int ptr_w     = ptr_width(num_ports)
) (
    input  logic [num_ports-1:0] req_valid,
`ifndef SPRAM_ARBITER_FIXED_PRIO_EN
    input  logic [ptr_w-1:0]     rr_ptr,
`endif
    output logic [num_ports-1:0] grant,
    output logic [ptr_w-1:0]     grant_idx,
    output logic                 grant_any
);

    int cand;

    // NOTE: every output gets a default before the search loop, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 0; k < num_ports; k++) begin
`ifdef SPRAM_ARBITER_FIXED_PRIO_EN
            cand = k;
`else
            cand = (int'(rr_ptr) + k) % num_ports;
`endif
            if (!grant_any && req_valid[ptr_w'(cand)]) begin
                grant_any               = 1'b1;
                grant[ptr_w'(cand)]     = 1'b1;
                grant_idx               = ptr_w'(cand);
            end
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port synchronous RAM between num_ports requesters.
// Optional build macro: SPRAM_ARBITER_FIXED_PRIO_EN (fixed priority, no rr_ptr).
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int address_width = 8,
    parameter int data_width    = 8,
    parameter int num_ports     = 2
) (
    input  logic           clk,
    input  logic           reset,
    spram_arbiter_if.slave bus
);

    localparam int PTR_W = ptr_width(num_ports);

    logic [num_ports-1:0] grant;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 accept;
    acc_e                 acc_kind;
    logic [num_ports-1:0] rsp_valid_d, rsp_valid_q;
`ifndef SPRAM_ARBITER_FIXED_PRIO_EN
    logic [PTR_W-1:0]     rr_ptr_d, rr_ptr_q;
`endif

    spram_arbiter_rr #(
        .num_ports (num_ports),
        .ptr_w     (PTR_W)
    ) u_rr (
        .req_valid (bus.req_valid),
`ifndef SPRAM_ARBITER_FIXED_PRIO_EN
        .rr_ptr    (rr_ptr_q),
`endif
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // The granted port drives the RAM in the same cycle; reset gates the grant.
    always_comb begin
        accept          = grant_any && !reset;
        acc_kind        = acc_e'(bus.req_wren[grant_idx]);
        bus.req_ready   = accept ? grant : '0;
        bus.ram_wren    = 1'b0;
        bus.ram_address = '0;
        bus.ram_data    = '0;
        rsp_valid_d     = '0;
        if (accept) begin
            bus.ram_wren    = (acc_kind == ACC_WRITE);
            bus.ram_address = bus.req_address[field_lsb(int'(grant_idx), address_width) +: address_width];
            bus.ram_data    = bus.req_data[field_lsb(int'(grant_idx), data_width) +: data_width];
            if (acc_kind == ACC_READ) begin
                rsp_valid_d = grant;
            end
        end
`ifndef SPRAM_ARBITER_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == PTR_W'(num_ports - 1)) ? '0 : grant_idx + 1'b1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
`ifndef SPRAM_ARBITER_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
`ifndef SPRAM_ARBITER_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Read data lands one cycle after accept; clients qualify it with rsp_valid.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = bus.ram_q;

endmodule
